axis_frame_arbiter: RTL and testbench
=====================================

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 32, meaning TDATA width in bits (multiple of 8).
REQ-002 SHALL have parameter PIXELS_VERTICAL, default 1024, meaning lines (TLAST packets) per frame, range 1..4095.
REQ-003 SHALL have port AXIS_ACLK, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port AXIS_ARESETN, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have, per requester n in {0,1}, ports S0n_AXIS_TVALID in 1, S0n_AXIS_TDATA in C_AXIS_TDATA_WIDTH, S0n_AXIS_TSTRB in C_AXIS_TDATA_WIDTH/8, S0n_AXIS_TLAST in 1, S0n_AXIS_TUSER in 1 (start of frame), S0n_AXIS_TREADY out 1.
REQ-006 SHALL have output ports M_AXIS_TVALID 1, M_AXIS_TDATA C_AXIS_TDATA_WIDTH, M_AXIS_TSTRB C_AXIS_TDATA_WIDTH/8, M_AXIS_TLAST 1, M_AXIS_USER 1, and input port M_AXIS_TREADY 1.
REQ-007 SHALL have output ARB_GRANT, 2 bits, one-hot current owner (00 = none).
REQ-008 SHALL have output ARB_LINE_CNT, 12 bits, lines completed in the current frame.
REQ-009 SHALL have output ARB_DROP_CNT, 16 bits, beats discarded while aligning to the start of frame.

Function
REQ-010 SHALL implement states IDLE, GRANT0 and GRANT1; ownership changes only at a frame boundary.
REQ-011 In IDLE, requester n is requesting when S0n_AXIS_TVALID=1.
REQ-012 From IDLE with one requester: next state is GRANTn.
REQ-013 From IDLE with both requesting: grant goes to the requester other than last_served (round-robin).
REQ-014 From IDLE with no requester: state remains IDLE.
REQ-015 In IDLE: M_AXIS_TVALID=0 and both S0n_AXIS_TREADY=0, except for draining under REQ-027.
REQ-016 In GRANTn, the path is combinational with zero latency: M_AXIS_TVALID/TDATA/TSTRB/TLAST/USER = S0n values and S0n_AXIS_TREADY = M_AXIS_TREADY; the other TREADY is 0.
REQ-017 In IDLE, M_AXIS_TDATA, TSTRB, TLAST and USER SHALL be 0.
REQ-018 Each beat with M_AXIS_TVALID&M_AXIS_TREADY&M_AXIS_TLAST in GRANTn SHALL increment ARB_LINE_CNT.
REQ-019 When that beat arrives with ARB_LINE_CNT==PIXELS_VERTICAL-1: ARB_LINE_CNT<=0, last_served<=n, state<=IDLE.
REQ-020 Minimum gap between frames is one idle cycle: frame-end TLAST in cycle t, IDLE in t+1, new grant effective in t+2.
REQ-021 Requests from the non-owner during GRANTn are ignored and never affect the current frame.
REQ-022 ARB_GRANT = 01 in GRANT0, 10 in GRANT1, 00 in IDLE; registered and consistent with the state.

Reset
REQ-023 With AXIS_ARESETN=0 at a clock edge: state<=IDLE, last_served<=1 (requester 0 wins the first tie), ARB_LINE_CNT<=0, ARB_DROP_CNT<=0.
REQ-024 During and after reset: all outputs SHALL be 0, including both TREADYs and ARB_GRANT.
REQ-025 A reset asserted mid-frame SHALL abandon the frame; no partial-frame state survives.

Configuration
REQ-026 Macro AXIS_ARB_SOF_ALIGN_EN selects start-of-frame alignment.
REQ-027 With the macro defined: in IDLE, a requester with TVALID=1 and TUSER=0 is drained (its TREADY=1, data discarded) and each drained beat increments ARB_DROP_CNT (saturating at 16'hFFFF). Only TVALID&TUSER counts as a request. The grant takes effect the next cycle, and the TUSER beat is then transferred.
REQ-028 Without the macro: REQ-011 applies as written, no draining occurs, and ARB_DROP_CNT is tied to 0.

Verification (bench PIXELS_VERTICAL=4)
REQ-029 Only S00 valid, 4 lines of 8 beats, M_AXIS_TREADY=1 -> ARB_GRANT=01 from cycle 2; 32 beats pass bit-exact; ARB_LINE_CNT steps 1,2,3,0; IDLE follows the 4th TLAST.
REQ-030 Both valid from reset -> frame 0 from S00, then one IDLE cycle, frame 1 from S01, then S00; strict alternation over 6 frames.
REQ-031 S01 raises TVALID mid-frame of S00 -> S01_AXIS_TREADY stays 0 until S00's 4th TLAST; no S01 beat appears on M before that.
REQ-032 M_AXIS_TREADY toggles at random 50% during GRANT0 -> S00_AXIS_TREADY mirrors it every cycle; no beat lost or duplicated; TLAST count equals 4.
REQ-033 Reset pulsed at line 2 of a GRANT1 frame -> next cycle all outputs 0, ARB_LINE_CNT=0; after release, a tie grants S00 first.
REQ-034 With AXIS_ARB_SOF_ALIGN_EN: S00 presents 3 beats with TUSER=0, then a TUSER=1 beat -> ARB_DROP_CNT=3; the first M beat carries M_AXIS_USER=1 and the TUSER-beat data.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_frame_arbiter
//
// Purpose:
//   Two-requester AXI4-Stream arbiter that hands the master port to one slave
//   for a whole video frame (PIXELS_VERTICAL TLAST-terminated lines). Ownership
//   only changes at a frame boundary. Ties are broken round-robin against the
//   requester served last. The data path is combinational with zero latency
//   while a grant is held.
//
// Optional feature:
//   `define AXIS_ARB_SOF_ALIGN_EN enables start-of-frame alignment. While no
//   grant is held, a requester whose current beat has TUSER=0 is drained
//   (accepted and discarded) and counted in ARB_DROP_CNT. Only a TUSER=1 beat
//   counts as a request. Without the macro any TVALID is a request and
//   ARB_DROP_CNT is held at zero.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESETN          clock, synchronous active-low reset
//   S00_AXIS_*, S01_AXIS_*           slave streams (TVALID/TDATA/TSTRB/TLAST/
//                                    TUSER in, TREADY out)
//   M_AXIS_*                         master stream (TVALID/TDATA/TSTRB/TLAST/
//                                    USER out, TREADY in)
//   ARB_GRANT[1:0]                   one-hot current owner, 00 = none
//   ARB_LINE_CNT[11:0]               lines completed in the current frame
//   ARB_DROP_CNT[15:0]               beats drained while aligning to SOF
// -----------------------------------------------------------------------------
module axis_frame_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int PIXELS_VERTICAL    = 1024
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  // requester 0
  input  logic                            S00_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S00_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S00_AXIS_TSTRB,
  input  logic                            S00_AXIS_TLAST,
  input  logic                            S00_AXIS_TUSER,
  output logic                            S00_AXIS_TREADY,
  // requester 1
  input  logic                            S01_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S01_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S01_AXIS_TSTRB,
  input  logic                            S01_AXIS_TLAST,
  input  logic                            S01_AXIS_TUSER,
  output logic                            S01_AXIS_TREADY,
  // master
  output logic                            M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_USER,
  input  logic                            M_AXIS_TREADY,
  // status
  output logic [1:0]                      ARB_GRANT,
  output logic [11:0]                     ARB_LINE_CNT,
  output logic [15:0]                     ARB_DROP_CNT
);

  localparam int          STRB_W    = C_AXIS_TDATA_WIDTH / 8;
  localparam logic [11:0] LAST_LINE = 12'(PIXELS_VERTICAL - 1);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } state_e;

  state_e                   state_r;
  state_e                   next_state_s;
  logic                     last_served_r;
  logic [11:0]              line_cnt_r;

  logic                     req0_s;
  logic                     req1_s;

  logic                     m_tvalid_s;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_tdata_s;
  logic [STRB_W-1:0]        m_tstrb_s;
  logic                     m_tlast_s;
  logic                     m_user_s;
  logic                     s00_tready_s;
  logic                     s01_tready_s;

  logic                     beat_last_s;
  logic                     frame_end_s;

  // Saturating 16-bit add of a small increment.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    if (sum[16]) begin
      sat_add16 = 16'hFFFF;
    end else begin
      sat_add16 = sum[15:0];
    end
  endfunction

`ifdef AXIS_ARB_SOF_ALIGN_EN
  logic        drain0_s;
  logic        drain1_s;
  logic [1:0]  drop_inc_s;
  logic [15:0] drop_cnt_r;

  // Only a start-of-frame beat may win arbitration; anything else is drained.
  assign req0_s     = S00_AXIS_TVALID & S00_AXIS_TUSER;
  assign req1_s     = S01_AXIS_TVALID & S01_AXIS_TUSER;
  assign drain0_s   = (state_r == ST_IDLE) & S00_AXIS_TVALID & ~S00_AXIS_TUSER;
  assign drain1_s   = (state_r == ST_IDLE) & S01_AXIS_TVALID & ~S01_AXIS_TUSER;
  assign drop_inc_s = {1'b0, drain0_s} + {1'b0, drain1_s};

  // Drop counter: TREADY equals the drain flag, so every drain flag is a consumed beat.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      drop_cnt_r <= 16'd0;
    end else begin
      drop_cnt_r <= sat_add16(drop_cnt_r, drop_inc_s);
    end
  end
`else
  logic [15:0] drop_cnt_r;

  assign req0_s     = S00_AXIS_TVALID;
  assign req1_s     = S01_AXIS_TVALID;
  assign drop_cnt_r = sat_add16(16'd0, 2'd0);
`endif

  // A completed line is a TLAST handshake; the last line of the frame releases the grant.
  assign beat_last_s = m_tvalid_s & M_AXIS_TREADY & m_tlast_s;
  assign frame_end_s = beat_last_s & (line_cnt_r == LAST_LINE);

  // State register, line counter and round-robin memory.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_r       <= ST_IDLE;
      last_served_r <= 1'b1;
      line_cnt_r    <= 12'd0;
    end else begin
      state_r <= next_state_s;
      if (frame_end_s) begin
        line_cnt_r    <= 12'd0;
        last_served_r <= (state_r == ST_GRANT1);
      end else if (beat_last_s) begin
        line_cnt_r    <= line_cnt_r + 12'd1;
        last_served_r <= last_served_r;
      end else begin
        line_cnt_r    <= line_cnt_r;
        last_served_r <= last_served_r;
      end
    end
  end

  // Next-state logic: arbitration happens only in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req0_s && req1_s) begin
          // last_served_r=1 means requester 1 went last, so 0 wins the tie.
          next_state_s = last_served_r ? ST_GRANT0 : ST_GRANT1;
        end else if (req0_s) begin
          next_state_s = ST_GRANT0;
        end else if (req1_s) begin
          next_state_s = ST_GRANT1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT0: begin
        if (frame_end_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GRANT0;
        end
      end
      ST_GRANT1: begin
        if (frame_end_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GRANT1;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output mux: zero-latency pass-through of the owner; everything quiet in
  // IDLE (apart from draining) and while reset is held low.
  always_comb begin
    m_tvalid_s   = 1'b0;
    m_tdata_s    = {C_AXIS_TDATA_WIDTH{1'b0}};
    m_tstrb_s    = {STRB_W{1'b0}};
    m_tlast_s    = 1'b0;
    m_user_s     = 1'b0;
    s00_tready_s = 1'b0;
    s01_tready_s = 1'b0;
    if (AXIS_ARESETN) begin
      case (state_r)
        ST_GRANT0: begin
          m_tvalid_s   = S00_AXIS_TVALID;
          m_tdata_s    = S00_AXIS_TDATA;
          m_tstrb_s    = S00_AXIS_TSTRB;
          m_tlast_s    = S00_AXIS_TLAST;
          m_user_s     = S00_AXIS_TUSER;
          s00_tready_s = M_AXIS_TREADY;
        end
        ST_GRANT1: begin
          m_tvalid_s   = S01_AXIS_TVALID;
          m_tdata_s    = S01_AXIS_TDATA;
          m_tstrb_s    = S01_AXIS_TSTRB;
          m_tlast_s    = S01_AXIS_TLAST;
          m_user_s     = S01_AXIS_TUSER;
          s01_tready_s = M_AXIS_TREADY;
        end
        ST_IDLE: begin
`ifdef AXIS_ARB_SOF_ALIGN_EN
          s00_tready_s = drain0_s;
          s01_tready_s = drain1_s;
`else
          s00_tready_s = 1'b0;
          s01_tready_s = 1'b0;
`endif
        end
        default: begin
          m_tvalid_s = 1'b0;
        end
      endcase
    end else begin
      m_tvalid_s   = 1'b0;
      s00_tready_s = 1'b0;
      s01_tready_s = 1'b0;
    end
  end

  assign M_AXIS_TVALID   = m_tvalid_s;
  assign M_AXIS_TDATA    = m_tdata_s;
  assign M_AXIS_TSTRB    = m_tstrb_s;
  assign M_AXIS_TLAST    = m_tlast_s;
  assign M_AXIS_USER     = m_user_s;
  assign S00_AXIS_TREADY = s00_tready_s;
  assign S01_AXIS_TREADY = s01_tready_s;

  // Status outputs come straight from registers; the reset term keeps them at
  // zero from the moment reset is asserted, not only after the next edge.
  assign ARB_GRANT    = AXIS_ARESETN ? state_r    : 2'b00;
  assign ARB_LINE_CNT = AXIS_ARESETN ? line_cnt_r : 12'd0;
  assign ARB_DROP_CNT = AXIS_ARESETN ? drop_cnt_r : 16'd0;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_arbiter
//
// Directed bench for axis_frame_arbiter with PIXELS_VERTICAL=4. Each test
// loads per-requester beat queues and pushes the beats it expects on the
// master port into a scoreboard queue; a monitor process pops and compares on
// every master handshake and also tracks the line counter.
// -----------------------------------------------------------------------------
module tb_axis_frame_arbiter;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int PV = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s00_tvalid, s01_tvalid;
  logic [DW-1:0] s00_tdata, s01_tdata;
  logic [SW-1:0] s00_tstrb, s01_tstrb;
  logic          s00_tlast, s01_tlast, s00_tuser, s01_tuser;
  logic          s00_tready, s01_tready;
  logic          m_tvalid, m_tlast, m_user, m_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [1:0]    arb_grant;
  logic [11:0]   arb_line_cnt;
  logic [15:0]   arb_drop_cnt;

  beat_t src_q0[$];
  beat_t src_q1[$];
  beat_t exp_q[$];

  logic en0, en1, rand_ready, chk_mirror, chk_s01_block;
  logic hs0, hs1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tlast_cnt = 0;

  always #5 clk = ~clk;

  axis_frame_arbiter #(
    .C_AXIS_TDATA_WIDTH(DW),
    .PIXELS_VERTICAL   (PV)
  ) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rstn),
    .S00_AXIS_TVALID(s00_tvalid),
    .S00_AXIS_TDATA (s00_tdata),
    .S00_AXIS_TSTRB (s00_tstrb),
    .S00_AXIS_TLAST (s00_tlast),
    .S00_AXIS_TUSER (s00_tuser),
    .S00_AXIS_TREADY(s00_tready),
    .S01_AXIS_TVALID(s01_tvalid),
    .S01_AXIS_TDATA (s01_tdata),
    .S01_AXIS_TSTRB (s01_tstrb),
    .S01_AXIS_TLAST (s01_tlast),
    .S01_AXIS_TUSER (s01_tuser),
    .S01_AXIS_TREADY(s01_tready),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TSTRB   (m_tstrb),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_USER    (m_user),
    .M_AXIS_TREADY  (m_tready),
    .ARB_GRANT      (arb_grant),
    .ARB_LINE_CNT   (arb_line_cnt),
    .ARB_DROP_CNT   (arb_drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present the head of each source queue (or idle) on the slave ports.
  task automatic drive_srcs();
    if (en0 && src_q0.size() > 0) begin
      s00_tvalid = 1'b1;
      {s00_tdata, s00_tstrb, s00_tlast, s00_tuser} = src_q0[0];
    end else begin
      s00_tvalid = 1'b0;
      {s00_tdata, s00_tstrb, s00_tlast, s00_tuser} = '0;
    end
    if (en1 && src_q1.size() > 0) begin
      s01_tvalid = 1'b1;
      {s01_tdata, s01_tstrb, s01_tlast, s01_tuser} = src_q1[0];
    end else begin
      s01_tvalid = 1'b0;
      {s01_tdata, s01_tstrb, s01_tlast, s01_tuser} = '0;
    end
  endtask

  // Advance one clock: retire accepted source beats, then drive the next ones.
  task automatic step();
    beat_t tmp;
    @(posedge clk);
    #1;
    if (hs0 && src_q0.size() > 0) tmp = src_q0.pop_front();
    if (hs1 && src_q1.size() > 0) tmp = src_q1.pop_front();
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
    drive_srcs();
  endtask

  // One frame of `lines` lines x `bpl` beats; the first `nexp` beats are expected on M.
  task automatic load_frame(input int src, input int id, input int lines, input int bpl, input int nexp);
    beat_t b;
    int    idx = 0;
    for (int l = 0; l < lines; l++) begin
      for (int k = 0; k < bpl; k++) begin
        b.data = 32'((src << 28) | (id << 16) | (l << 8) | k);
        b.strb = 4'((l + k + src) % 16) | 4'b0001;
        b.last = (k == bpl - 1);
        b.user = (l == 0 && k == 0);
        if (src == 0) src_q0.push_back(b); else src_q1.push_back(b);
        if (idx < nexp) exp_q.push_back(b);
        idx++;
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; en0 = 1'b0; en1 = 1'b0; m_tready = 1'b1;
    rand_ready = 1'b0; chk_mirror = 1'b0; chk_s01_block = 1'b0;
    src_q0.delete(); src_q1.delete(); exp_q.delete();
    drive_srcs();
    repeat (2) step();
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Handshake capture for the source drivers.
  initial begin
    hs0 = 1'b0; hs1 = 1'b0;
    forever begin
      @(negedge clk);
      hs0 = s00_tvalid & s00_tready;
      hs1 = s01_tvalid & s01_tready;
    end
  end

  // Monitor / scoreboard.
  initial begin
    int    exp_line = 0;
    logic  prev_last = 1'b0;
    beat_t got, e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_line  = 0;
        prev_last = 1'b0;
      end else begin
        if (prev_last) begin
          exp_line = (exp_line + 1) % PV;
          check("line_cnt", 64'(arb_line_cnt), 64'(exp_line));
        end
        prev_last = 1'b0;
        if (m_tvalid && m_tready) begin
          got = {m_tdata, m_tstrb, m_tlast, m_user};
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got %0h with nothing expected (t=%0t)", got, $time);
          end else begin
            e = exp_q.pop_front();
            check("m_beat", 64'(got), 64'(e));
          end
          if (m_tlast) begin
            prev_last = 1'b1;
            tlast_cnt++;
          end
        end
        if (chk_mirror && arb_grant == 2'b01) check("s00_tready_mirror", 64'(s00_tready), 64'(m_tready));
        if (chk_s01_block && arb_grant == 2'b01) check("s01_tready_blocked", 64'(s01_tready), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // ---- T1: reset state, single requester, 4 lines x 8 beats ----
    do_reset();
    load_frame(0, 1, PV, 8, PV * 8);
    en0 = 1'b1;
    drive_srcs();
    repeat (2) step();
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_s00_tready", 64'(s00_tready), 64'd0);
    check("rst_grant", 64'(arb_grant), 64'd0);
    check("rst_line_cnt", 64'(arb_line_cnt), 64'd0);
    check("rst_drop_cnt", 64'(arb_drop_cnt), 64'd0);
    rstn = 1'b1;
    step();
    check("t1_grant0", 64'(arb_grant), 64'h1);
    wait_done("t1_done", 200);
    check("t1_idle_after", 64'(arb_grant), 64'd0);
    check("t1_line_cnt_wrap", 64'(arb_line_cnt), 64'd0);

    // ---- T2: both requesting, strict alternation over 6 frames ----
    do_reset();
    for (int f = 0; f < 6; f++) load_frame(f % 2, 2 + f, PV, 2, PV * 2);
    en0 = 1'b1; en1 = 1'b1;
    rstn = 1'b1;
    drive_srcs();
    step();
    for (int f = 0; f < 6; f++) begin
      check("t2_grant", 64'(arb_grant), (f % 2 == 0) ? 64'h1 : 64'h2);
      k = 0;
      while (arb_grant != 2'b00 && k < 100) begin
        step();
        k++;
      end
      check("t2_idle_gap", 64'(arb_grant), 64'd0);
      step();
    end
    check("t2_done", 64'(exp_q.size()), 64'd0);

    // ---- T3: S01 raises TVALID mid-frame of S00 ----
    do_reset();
    load_frame(0, 10, PV, 4, PV * 4);
    load_frame(1, 11, PV, 2, PV * 2);
    en0 = 1'b1;
    chk_s01_block = 1'b1;
    rstn = 1'b1;
    drive_srcs();
    repeat (5) step();
    en1 = 1'b1;
    drive_srcs();
    wait_done("t3_done", 200);
    chk_s01_block = 1'b0;

    // ---- T4: random M_AXIS_TREADY during GRANT0 ----
    do_reset();
    load_frame(0, 20, PV, 3, PV * 3);
    en0 = 1'b1;
    rand_ready = 1'b1;
    chk_mirror = 1'b1;
    tlast_cnt = 0;
    rstn = 1'b1;
    drive_srcs();
    wait_done("t4_done", 400);
    chk_mirror = 1'b0;
    rand_ready = 1'b0;
    m_tready = 1'b1;
    check("t4_tlast_cnt", 64'(tlast_cnt), 64'(PV));

    // ---- T5: reset at line 2 of a GRANT1 frame ----
    do_reset();
    load_frame(1, 30, PV, 2, 4);
    en1 = 1'b1;
    rstn = 1'b1;
    drive_srcs();
    k = 0;
    while (arb_line_cnt != 12'd2 && k < 100) begin
      step();
      k++;
    end
    check("t5_grant1_mid", 64'(arb_grant), 64'h2);
    rstn = 1'b0;
    step();
    check("t5_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_rst_m_tdata", 64'(m_tdata), 64'd0);
    check("t5_rst_s01_tready", 64'(s01_tready), 64'd0);
    check("t5_rst_grant", 64'(arb_grant), 64'd0);
    check("t5_rst_line_cnt", 64'(arb_line_cnt), 64'd0);
    check("t5_partial_beats", 64'(exp_q.size()), 64'd0);
    src_q0.delete(); src_q1.delete();
    load_frame(0, 31, PV, 2, PV * 2);
    load_frame(1, 32, PV, 2, PV * 2);
    en0 = 1'b1; en1 = 1'b1;
    rstn = 1'b1;
    drive_srcs();
    step();
    check("t5_tie_after_reset", 64'(arb_grant), 64'h1);
    wait_done("t5_done", 200);

    // ---- T6: start-of-frame alignment / drop counter ----
    do_reset();
`ifdef AXIS_ARB_SOF_ALIGN_EN
    for (int j = 0; j < 3; j++) begin
      beat_t jb;
      jb.data = 32'hDEAD_0000 | 32'(j);
      jb.strb = 4'hF;
      jb.last = 1'b0;
      jb.user = 1'b0;
      src_q0.push_back(jb);
    end
    load_frame(0, 40, PV, 2, PV * 2);
    en0 = 1'b1;
    rstn = 1'b1;
    drive_srcs();
    wait_done("t6_done", 200);
    check("t6_drop_cnt", 64'(arb_drop_cnt), 64'd3);
`else
    load_frame(0, 40, PV, 2, PV * 2);
    en0 = 1'b1;
    rstn = 1'b1;
    drive_srcs();
    wait_done("t6_done", 200);
    check("t6_drop_cnt_tied", 64'(arb_drop_cnt), 64'd0);
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
